// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF response collector.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_OUT
  } state_t;

  localparam int unsigned DEF_N_CB = 64;
  localparam logic [DEF_N_CB-1:0] DEF_TAPS = 64'hD800000000000000;

  // Counter width able to hold values 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/puf_lfsr.sv
// Challenge register: loadable Fibonacci LFSR with zero-seed substitution.
module puf_lfsr #(
  parameter int unsigned       N_CB = 64,
  parameter logic [N_CB-1:0]   TAPS = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [N_CB-1:0] seed,
  input  logic            step,
  output logic [N_CB-1:0] q
);

  logic [N_CB-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      // An all-zero state would lock the LFSR, so substitute 1.
      lfsr_d = (seed == '0) ? N_CB'(1) : seed;
    end else if (step) begin
      lfsr_d = {lfsr_q[N_CB-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/puf_resp_collector.sv
// Challenge sequencer and majority-vote response collector for a 1-bit arbiter PUF.
// Optional macro PUF_COLLECT_STATS_EN adds the unstable_cnt output.
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int unsigned     N_CB   = 64,
  parameter int unsigned     N_RESP = 32,
  parameter int unsigned     N_EVAL = 5,
  parameter int unsigned     SETTLE = 4,
  parameter logic [N_CB-1:0] TAPS   = N_CB'(DEF_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_CB-1:0]   seed,
  output logic              busy,
  output logic [N_CB-1:0]   challenge,
  input  logic              response,
  output logic [N_RESP-1:0] resp_word,
  output logic              resp_valid,
  input  logic              resp_ready
`ifdef PUF_COLLECT_STATS_EN
  ,
  output logic [$clog2(N_RESP+1)-1:0] unstable_cnt
`endif
);

  localparam int unsigned EW = cnt_w(N_EVAL + 1);
  localparam int unsigned BW = cnt_w(N_RESP + 1);
  localparam int unsigned SW = cnt_w(SETTLE + 1);

  state_t            state_q, state_d;
  logic [EW-1:0]     eval_q, eval_d, ones_q, ones_d, ones_new;
  logic [BW-1:0]     bit_q, bit_d;
  logic [SW-1:0]     set_q, set_d;
  logic [N_RESP-1:0] resp_word_q, resp_word_d;
  logic              resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;
  logic              lfsr_load, lfsr_step, vote;
  state_t            after_sample;
`ifdef PUF_COLLECT_STATS_EN
  logic [BW-1:0]     unstable_q, unstable_d;
`endif

  puf_lfsr #(.N_CB(N_CB), .TAPS(TAPS)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (lfsr_step),
    .q    (challenge)
  );

  assign ones_new     = ones_q + EW'(response);
  assign vote         = ones_new > EW'(N_EVAL / 2);
  assign after_sample = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  always_comb begin
    state_d      = state_q;
    eval_d       = eval_q;
    ones_d       = ones_q;
    bit_d        = bit_q;
    set_d        = set_q;
    resp_word_d  = resp_word_q;
    resp_valid_d = resp_valid_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
`ifdef PUF_COLLECT_STATS_EN
    unstable_d   = unstable_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_load   = 1'b1;
          eval_d      = '0;
          ones_d      = '0;
          bit_d       = '0;
          set_d       = '0;
          resp_word_d = '0;
`ifdef PUF_COLLECT_STATS_EN
          unstable_d  = '0;
`endif
          state_d     = after_sample;
        end
      end
      ST_SETTLE: begin
        if (int'(set_q) >= int'(SETTLE) - 1) begin
          set_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          set_d = set_q + SW'(1);
        end
      end
      ST_SAMPLE: begin
        if (int'(eval_q) < int'(N_EVAL) - 1) begin
          eval_d  = eval_q + EW'(1);
          ones_d  = ones_new;
          state_d = after_sample;
        end else begin
          for (int unsigned i = 0; i < N_RESP; i++) begin
            if (bit_q == BW'(i)) resp_word_d[i] = vote;
          end
`ifdef PUF_COLLECT_STATS_EN
          if (ones_new != '0 && ones_new != EW'(N_EVAL)) unstable_d = unstable_q + BW'(1);
`endif
          lfsr_step = 1'b1;
          eval_d    = '0;
          ones_d    = '0;
          bit_d     = bit_q + BW'(1);
          state_d   = (int'(bit_q) == int'(N_RESP) - 1) ? ST_OUT : after_sample;
        end
      end
      ST_OUT: begin
        // resp_valid is raised on the cycle after entry, giving one registered stage.
        resp_valid_d = 1'b1;
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      eval_q       <= '0;
      ones_q       <= '0;
      bit_q        <= '0;
      set_q        <= '0;
      resp_word_q  <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PUF_COLLECT_STATS_EN
      unstable_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      bit_q        <= bit_d;
      set_q        <= set_d;
      resp_word_q  <= resp_word_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef PUF_COLLECT_STATS_EN
      unstable_q   <= unstable_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign resp_word  = resp_word_q;
  assign resp_valid = resp_valid_q;
`ifdef PUF_COLLECT_STATS_EN
  assign unstable_cnt = unstable_q;
`endif

endmodule

// File: doc/puf_resp_collector.md
Name: puf_resp_collector

Overview:
- Challenge-sequencing and response-collection stage wrapped around a single-bit arbiter PUF.
- Drives the PUF challenge bus from an LFSR seeded by the host and holds each challenge for a settle window.
- Samples the 1-bit PUF response N_EVAL times per challenge, majority-votes the samples, and packs N_RESP voted bits into a word.
- Delivers the word to the host/ECC stage over a valid/ready handshake.

Parameters:
- N_CB, 64, challenge width; must match the PUF's challenge bus.
- N_RESP, 32, voted response bits per output word (1..256).
- N_EVAL, 5, evaluations per challenge; must be odd, ≥1.
- SETTLE, 4, cycles a challenge is held before each sample (≥0).
- TAPS, 64'hD800000000000000, LFSR feedback mask (N_CB bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new word; honoured only in IDLE
- seed  in  N_CB  initial challenge, sampled with start
- busy  out  1  high in every state except IDLE
- challenge  out  N_CB  to PUF challenge input; registered
- response  in  1  from PUF response output
- resp_word  out  N_RESP  collected word; bit i = voted result of i-th challenge
- resp_valid  out  1  resp_word valid
- resp_ready  in  1  consumer accepts resp_word

Behaviour:
- Reset (sync, active-high, clk edge): state IDLE; challenge, resp_word, all counters 0; resp_valid 0; busy 0. Takes priority over everything, in any state; an in-progress collection is abandoned with no partial output.
- IDLE:
  - start=1 → challenge <= seed (seed==0 replaced by 1 to avoid LFSR lock-up).
  - Clear ones_cnt, eval_cnt, bit_cnt, resp_word; next SETTLE.
- SETTLE:
  - Hold challenge for SETTLE cycles (settle counter 0..SETTLE-1), then SAMPLE.
  - SETTLE=0 goes straight to SAMPLE.
- SAMPLE (1 cycle):
  - ones_cnt += response.
  - If eval_cnt < N_EVAL-1: eval_cnt++, back to SETTLE with the same challenge.
  - Else:
    - vote = (ones_cnt_incl_this_sample > N_EVAL/2); resp_word[bit_cnt] <= vote.
    - challenge <= {challenge[N_CB-2:0], ^(challenge & TAPS)}.
    - eval_cnt, ones_cnt <= 0; bit_cnt++.
    - Next is OUT if bit_cnt was N_RESP-1, else SETTLE.
- OUT:
  - resp_valid=1; resp_word and challenge stable until resp_valid&resp_ready.
  - On handshake: resp_valid drops next cycle, return to IDLE.
  - start is ignored in OUT; accepted in IDLE at the earliest one cycle after the handshake.
- Latency: resp_valid rises N_RESP*N_EVAL*(SETTLE+1)+1 cycles after the clk edge that samples start.
- Counter widths: $clog2 of (N_EVAL+1), (N_RESP+1), (SETTLE+1); minimum 1 bit each.
- start while busy: ignored, no effect on sequence.
- resp_ready while not valid: ignored.

Optional Feature:
- Macro PUF_COLLECT_STATS_EN.
- When defined, adds output unstable_cnt [$clog2(N_RESP+1)-1:0]:
  - Counts challenges in the current word whose samples were not unanimous (0 < ones_cnt < N_EVAL).
  - Cleared on start acceptance and on reset.
  - Valid and stable alongside resp_valid.
- When undefined: port and logic are absent; behaviour otherwise identical.

Decomposition:
- Package puf_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, OUT)
  - default TAPS constant for 64-bit challenges
  - width helper constants
- One sub-module, puf_lfsr: N_CB-bit register with load (seed, zero-substitution) and step enable; it produces the challenge bus.

Test Plan:
- N_RESP=4, N_EVAL=3, SETTLE=2, seed=64'h1, response tied 1 → resp_word=4'hF, resp_valid rises exactly 37 cycles after start.
- N_RESP=16, N_EVAL=1, SETTLE=0, seed=64'h1, response=challenge[10] (model) → challenges 1,2,4,…; resp_word=16'h0400.
- N_EVAL=3; response follows per-evaluation pattern 1,1,0 on every challenge → all bits 1; with PUF_COLLECT_STATS_EN, unstable_cnt=N_RESP.
- seed=0 → first challenge observed =64'h1; sequence matches the seed=1 run.
- resp_ready held low 10 cycles in OUT, start pulsed there → resp_word/challenge stable, resp_valid high throughout, start ignored; handshake → IDLE, busy=0 next cycle.
- rst asserted at mid-word (bit_cnt=2) → next cycle busy=0, resp_valid=0, challenge=0; new start then produces a full, correct word.
